tangram_compositor: RTL and testbench

- Downstream of the seven per-piece shape renderers and the 800x600 VGA timing generator.
- Merges the seven 1-bit piece masks and a 1-bit target-silhouette mask into 12-bit RGB for the VGA DAC.
- Blinks the currently selected piece.
- Counts uncovered silhouette pixels each frame and raises a solved flag when the puzzle is complete.

---
 rtl/tangram_pkg.sv | 36 +++
 rtl/tangram_frame_stats.sv | 65 ++++++
 rtl/tangram_compositor.sv | 114 +++++++++++
 tb/tb_tangram_compositor.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/tangram_pkg.sv
// Shared constants, palette and saturating-count helper for the tangram display path.
package tangram_pkg;

    localparam int NPIECE = 7;

    localparam logic [10:0] H_MIN = 11'd215;
    localparam logic [10:0] V_MIN = 11'd26;
    localparam logic [10:0] H_MAX = 11'd1015;
    localparam logic [10:0] V_MAX = 11'd626;

    localparam logic [11:0] SILHOUETTE_GREY = 12'h444;
    localparam logic [11:0] BACKGROUND      = 12'h113;
    localparam logic [11:0] HIGHLIGHT       = 12'hFFF;

    localparam logic [19:0] ACC_MAX = 20'hFFFFF;

    function automatic logic [11:0] palette(input logic [2:0] idx);
        logic [11:0] c;
        case (idx)
            3'd0:    c = 12'hF00;
            3'd1:    c = 12'h0F0;
            3'd2:    c = 12'h00F;
            3'd3:    c = 12'hFF0;
            3'd4:    c = 12'hF0F;
            3'd5:    c = 12'h0FF;
            3'd6:    c = 12'hF80;
            default: c = 12'h000;
        endcase
        return c;
    endfunction

    function automatic logic [19:0] sat_inc(input logic [19:0] v);
        return (v == ACC_MAX) ? v : v + 20'd1;
    endfunction

endpackage

// File: rtl/tangram_frame_stats.sv
// Frame-tick detection plus per-frame silhouette coverage accounting.
module tangram_frame_stats
    import tangram_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        raw,
    input  logic        vidon,
    input  logic        target_hit,
    input  logic        any_hit,
    output logic        tick,
    output logic [19:0] uncovered_cnt,
    output logic        solved
);

    logic        raw_prev_r;
    logic        armed_r;
    logic [19:0] tgt_acc_r;
    logic [19:0] unc_acc_r;
    logic        count_tgt_s;
    logic        count_unc_s;
    logic [19:0] tgt_nxt_s;
    logic [19:0] unc_nxt_s;

    assign tick = raw & ~raw_prev_r;

    // Next accumulator values; the tick pixel itself opens the new frame.
    always_comb begin
        count_tgt_s = vidon & target_hit;
        count_unc_s = count_tgt_s & ~any_hit;
        if (tick) begin
            tgt_nxt_s = {19'd0, count_tgt_s};
            unc_nxt_s = {19'd0, count_unc_s};
        end else begin
            tgt_nxt_s = count_tgt_s ? sat_inc(tgt_acc_r) : tgt_acc_r;
            unc_nxt_s = count_unc_s ? sat_inc(unc_acc_r) : unc_acc_r;
        end
    end

    // Edge detect, arming and latching of the completed-frame result.
    always_ff @(posedge clk) begin
        if (rst) begin
            raw_prev_r    <= 1'b0;
            armed_r       <= 1'b0;
            tgt_acc_r     <= 20'd0;
            unc_acc_r     <= 20'd0;
            uncovered_cnt <= 20'd0;
            solved        <= 1'b0;
        end else begin
            raw_prev_r <= raw;
            armed_r    <= armed_r | tick;
            tgt_acc_r  <= tgt_nxt_s;
            unc_acc_r  <= unc_nxt_s;
            // The first tick after reset only arms: that frame was partial.
            if (tick && armed_r) begin
                uncovered_cnt <= unc_acc_r;
                solved        <= (unc_acc_r == 20'd0) && (tgt_acc_r != 20'd0);
            end else begin
                uncovered_cnt <= uncovered_cnt;
                solved        <= solved;
            end
        end
    end

endmodule

// File: rtl/tangram_compositor.sv
// Merges piece and silhouette masks into 12-bit RGB, blinks the selected piece,
// and reports per-frame silhouette coverage.
module tangram_compositor
    import tangram_pkg::*;
#(
    parameter int BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vidon,
    input  logic [10:0] hc,
    input  logic [10:0] vc,
    input  logic [6:0]  piece_hit,
    input  logic        target_hit,
    input  logic [2:0]  sel,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic [19:0] uncovered_cnt,
    output logic        solved
);

    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic              vid_r;
    logic [NPIECE-1:0] hit_r;
    logic              tgt_r;
    logic [2:0]        sel_r;
    logic              raw_r;
    logic [11:0]       rgb_r;
    logic [BW-1:0]     blink_cnt_r;
    logic              blink_phase_r;
    logic              tick_s;
    logic [11:0]       rgb_s;
    logic [2:0]        low_idx_s;
    logic [7:0]        hit_ext_s;
    logic              sel_ok_s;

    // Stage 1 input registers and stage 2 colour register.
    always_ff @(posedge clk) begin
        if (rst) begin
            vid_r <= 1'b0;
            hit_r <= '0;
            tgt_r <= 1'b0;
            sel_r <= 3'd7;
            raw_r <= 1'b0;
            rgb_r <= 12'h000;
        end else begin
            vid_r <= vidon;
            hit_r <= piece_hit;
            tgt_r <= target_hit;
            sel_r <= sel;
            raw_r <= (hc == H_MIN) && (vc == V_MIN);
            rgb_r <= rgb_s;
        end
    end

    // Blink half-period counter advanced once per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_r   <= '0;
            blink_phase_r <= 1'b0;
        end else if (tick_s) begin
            if (blink_cnt_r == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_r   <= '0;
                blink_phase_r <= ~blink_phase_r;
            end else begin
                blink_cnt_r   <= blink_cnt_r + BW'(1);
                blink_phase_r <= blink_phase_r;
            end
        end else begin
            blink_cnt_r   <= blink_cnt_r;
            blink_phase_r <= blink_phase_r;
        end
    end

    // Colour priority: blanking, selected piece, lowest piece, silhouette, background.
    always_comb begin
        low_idx_s = 3'd0;
        for (int i = NPIECE - 1; i >= 0; i--) begin
            low_idx_s = hit_r[i] ? 3'(i) : low_idx_s;
        end
        hit_ext_s = {1'b0, hit_r};
        sel_ok_s  = (sel_r < 3'(NPIECE));
        if (!vid_r) begin
            rgb_s = 12'h000;
        end else if (sel_ok_s && hit_ext_s[sel_r]) begin
            rgb_s = blink_phase_r ? HIGHLIGHT : palette(sel_r);
        end else if (|hit_r) begin
            rgb_s = palette(low_idx_s);
        end else if (tgt_r) begin
            rgb_s = SILHOUETTE_GREY;
        end else begin
            rgb_s = BACKGROUND;
        end
    end

    tangram_frame_stats u_stats (
        .clk           (clk),
        .rst           (rst),
        .raw           (raw_r),
        .vidon         (vid_r),
        .target_hit    (tgt_r),
        .any_hit       (|hit_r),
        .tick          (tick_s),
        .uncovered_cnt (uncovered_cnt),
        .solved        (solved)
    );

    assign red   = rgb_r[11:8];
    assign green = rgb_r[7:4];
    assign blue  = rgb_r[3:0];

endmodule

// File: tb/tb_tangram_compositor.sv
// Scoreboard bench: stimulus pushes expected outputs from a frame-level model,
// a monitor pops and compares them as the DUT presents each pixel.
module tb_tangram_compositor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vidon = 1'b0;
    logic [10:0] hc = 11'd0;
    logic [10:0] vc = 11'd0;
    logic [6:0]  piece_hit = 7'd0;
    logic        target_hit = 1'b0;
    logic [2:0]  sel = 3'd7;
    logic [3:0]  red, green, blue;
    logic [19:0] uncovered_cnt;
    logic        solved;

    always #5 clk = ~clk;

    tangram_compositor dut (
        .clk           (clk),
        .rst           (rst),
        .vidon         (vidon),
        .hc            (hc),
        .vc            (vc),
        .piece_hit     (piece_hit),
        .target_hit    (target_hit),
        .sel           (sel),
        .red           (red),
        .green         (green),
        .blue          (blue),
        .uncovered_cnt (uncovered_cnt),
        .solved        (solved)
    );

    typedef struct {
        logic [11:0] rgb;
        logic [19:0] unc;
        logic        sol;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    logic [11:0] pal [7] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'hF0F, 12'h0FF, 12'hF80};

    // Frame-level reference state
    int ticks_seen = 0;
    bit armed = 0;
    bit prev_cond = 0;
    int acc_tgt = 0;
    int acc_unc = 0;
    int rep_unc = 0;
    bit rep_sol = 0;

    function automatic logic [11:0] colour(input logic v, input logic [6:0] hit,
                                           input logic t, input logic [2:0] s, input bit phase);
        if (!v) return 12'h000;
        if (s < 3'd7) begin
            if (hit[s]) return phase ? 12'hFFF : pal[s];
        end
        for (int i = 0; i < 7; i++) if (hit[i]) return pal[i];
        if (t) return 12'h444;
        return 12'h113;
    endfunction

    task automatic px(input logic r, input logic v, input logic [10:0] h, input logic [10:0] vv,
                      input logic [6:0] hit, input logic t, input logic [2:0] s);
        exp_t e;
        bit cond;
        @(negedge clk);
        rst = r; vidon = v; hc = h; vc = vv; piece_hit = hit; target_hit = t; sel = s;
        if (r) begin
            ticks_seen = 0; armed = 0; prev_cond = 0;
            acc_tgt = 0; acc_unc = 0; rep_unc = 0; rep_sol = 0;
            e = '{12'h000, 20'd0, 1'b0};
        end else begin
            cond = (h == 11'd215) && (vv == 11'd26);
            e.rgb = colour(v, hit, t, s, ((ticks_seen / 30) % 2) == 1);
            if (cond && !prev_cond) begin
                ticks_seen = (ticks_seen + 1) % 60;
                if (armed) begin
                    rep_unc = acc_unc;
                    rep_sol = (acc_unc == 0) && (acc_tgt != 0);
                end
                armed = 1;
                acc_tgt = 0;
                acc_unc = 0;
            end
            prev_cond = cond;
            if (v && t) begin
                if (acc_tgt < 20'hFFFFF) acc_tgt++;
                if (hit == 7'd0 && acc_unc < 20'hFFFFF) acc_unc++;
            end
            e.unc = 20'(rep_unc);
            e.sol = rep_sol;
        end
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) px(1'b0, 1'b0, 11'd0, 11'd0, 7'd0, 1'b0, 3'd7);
    endtask

    task automatic frame_tick(input int hold);
        repeat (hold) px(1'b0, 1'b0, 11'd215, 11'd26, 7'd0, 1'b0, 3'd7);
        px(1'b0, 1'b0, 11'd300, 11'd100, 7'd0, 1'b0, 3'd7);
    endtask

    task automatic unc_pix(input int n);
        repeat (n) px(1'b0, 1'b1, 11'd300, 11'd100, 7'd0, 1'b1, 3'd7);
    endtask

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    // Monitor: each edge presents the pixel driven two edges earlier.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() >= 2) begin
            e = q.pop_front();
            if (rst) e = '{12'h000, 20'd0, 1'b0};
            n_cmp++;
            if ({red, green, blue} !== e.rgb) begin
                n_bad++;
                $display("FAIL rgb at %0t: got %h required %h", $time, {red, green, blue}, e.rgb);
            end
            n_cmp++;
            if (uncovered_cnt !== e.unc || solved !== e.sol) begin
                n_bad++;
                $display("FAIL stats at %0t: got cnt=%0d solved=%0b required cnt=%0d solved=%0b",
                         $time, uncovered_cnt, solved, e.unc, e.sol);
            end
        end
    end

    initial begin
        // Reset held with live inputs
        repeat (3) px(1'b1, 1'b1, 11'd300, 11'd100, 7'($urandom), 1'b1, 3'd2);
        idle(1);
        chk("reset_cnt", int'(uncovered_cnt), 0);
        chk("reset_solved", int'(solved), 0);
        chk("reset_rgb", int'({red, green, blue}), 0);

        // Directed colour priority
        px(1'b0, 1'b1, 11'd300, 11'd100, 7'b0000110, 1'b0, 3'd7);
        px(1'b0, 1'b1, 11'd300, 11'd100, 7'b0000000, 1'b1, 3'd7);
        px(1'b0, 1'b1, 11'd300, 11'd100, 7'b0000000, 1'b0, 3'd7);
        px(1'b0, 1'b0, 11'd300, 11'd100, 7'b1111111, 1'b1, 3'd3);
        px(1'b0, 1'b1, 11'd300, 11'd100, 7'b1000010, 1'b1, 3'd6);
        idle(2);

        // Blink of selected piece 2, condition held 4 clk per frame
        for (int f = 1; f <= 62; f++) begin
            frame_tick(4);
            repeat (3) px(1'b0, 1'b1, 11'd300, 11'd100, 7'b0000100, 1'b0, 3'd2);
            if (f == 29 || f == 30 || f == 60)
                chk("blink", int'({red, green, blue}), (f == 30) ? 32'hFFF : 32'h00F);
        end

        // Coverage: arming frame, then reported frame
        px(1'b1, 1'b0, 11'd0, 11'd0, 7'd0, 1'b0, 3'd7);
        unc_pix(100);
        frame_tick(4);
        idle(2);
        chk("arm_cnt", int'(uncovered_cnt), 0);
        chk("arm_solved", int'(solved), 0);
        unc_pix(37);
        frame_tick(4);
        idle(2);
        chk("frameB_cnt", int'(uncovered_cnt), 37);
        chk("frameB_solved", int'(solved), 0);
        repeat (500) px(1'b0, 1'b1, 11'd300, 11'd100, 7'($urandom_range(1, 127)), 1'b1, 3'($urandom));
        frame_tick(1);
        idle(2);
        chk("covered_cnt", int'(uncovered_cnt), 0);
        chk("covered_solved", int'(solved), 1);
        repeat (50) px(1'b0, 1'($urandom), 11'd300, 11'd100, 7'($urandom), 1'b0, 3'($urandom));
        frame_tick(2);
        idle(2);
        chk("empty_solved", int'(solved), 0);

        // Mid-frame reset discards the partial count
        unc_pix(20);
        px(1'b1, 1'b0, 11'd0, 11'd0, 7'd0, 1'b0, 3'd7);
        unc_pix(5);
        frame_tick(3);
        unc_pix(5);
        frame_tick(3);
        idle(2);
        chk("after_rst_cnt", int'(uncovered_cnt), 5);

        // Randomised traffic with occasional frame conditions and resets
        repeat (600) begin
            if ($urandom_range(0, 7) == 0)
                px(($urandom_range(0, 99) == 0), 1'($urandom), 11'd215, 11'd26,
                   7'($urandom), 1'($urandom), 3'($urandom));
            else
                px(($urandom_range(0, 99) == 0), 1'($urandom), 11'($urandom_range(0, 1000)),
                   11'($urandom_range(0, 600)), ($urandom_range(0, 2) == 0) ? 7'd0 : 7'($urandom),
                   1'($urandom), 3'($urandom));
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
